conv33_stream: RTL

//  Streaming 3x3 convolution engine. Multi-channel, parametrised, with internal line buffers.

---
 rtl/conv33_stream_if.sv | 27 ++
 rtl/conv33_stream.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv33_stream_if.sv
// Stream bundle for conv33_stream: input pixel stream (s_*) and filtered output stream (m_*).
//   s_data/s_valid/s_sof  host -> engine, s_ready engine -> host
//   m_data/m_valid/m_sof/m_eol  engine -> sink, m_ready sink -> engine
// master: host/sink side (testbench or surrounding logic); slave: the engine.
interface conv33_stream_if #(
  parameter int unsigned DATA_W = 24
) ();
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_sof;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_sof;
  logic              m_eol;
  logic              m_ready;

  modport master (
    output s_data, s_valid, s_sof, m_ready,
    input  s_ready, m_data, m_valid, m_sof, m_eol
  );

  modport slave (
    input  s_data, s_valid, s_sof, m_ready,
    output s_ready, m_data, m_valid, m_sof, m_eol
  );
endinterface

// File: rtl/conv33_stream.sv
// Streaming 3x3 convolution engine with internal line buffers and zero padding on all borders.
// Raster-order pixels in, one filtered pixel out per input pixel, valid/ready on both sides.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   mode      kernel select (0 pass, 1 sharpen, 2 gauss, 3 edge), latched on an accepted s_sof beat
//   io        stream bundle (slave side): s_data/s_valid/s_sof/s_ready, m_data/m_valid/m_sof/m_eol/m_ready
//   busy      a frame is in progress
//   err_sof   one-cycle pulse after a beat without s_sof was accepted (and dropped) while idle
module conv33_stream #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 6,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CH    = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     mode,
  conv33_stream_if.slave io,
  output logic           busy,
  output logic           err_sof
);

  localparam int unsigned DATA_W = CH * PIX_W;
  localparam int unsigned ACC_W  = PIX_W + 5;
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  typedef logic [DATA_W-1:0] pix_t;
  // One window column: [0]=top row, [1]=middle row, [2]=bottom row.
  typedef logic [2:0][DATA_W-1:0] col_t;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_EOL, S_FLUSH} state_e;
  typedef enum logic [1:0] {M_PASS, M_SHARPEN, M_GAUSS, M_EDGE} mode_e;

  state_e state, state_nx;
  mode_e  mode_q;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  // line_a holds the previous row, line_b the row before that.
  pix_t line_a [IMG_W];
  pix_t line_b [IMG_W];

  // Left and centre columns of the window; the right column arrives with the input beat.
  col_t win_l_q, win_c_q;

  logic accept, out_free, restart;
  logic emit, emit_sof, emit_eol;
  col_t tap_l, tap_c, tap_r;
  pix_t result;

  assign accept   = io.s_valid && io.s_ready;
  assign out_free = !io.m_valid || io.m_ready;
  assign restart  = accept && io.s_sof;
  assign busy     = (state != S_IDLE);

  assign io.s_ready = (state == S_RUN) ? out_free
                                       : !((state == S_EOL) || (state == S_FLUSH));

  function automatic logic signed [ACC_W-1:0] samp(input pix_t p, input int unsigned k);
    return $signed(ACC_W'(p[k*PIX_W +: PIX_W]));
  endfunction

  function automatic pix_t kernel(input mode_e md, input col_t l, input col_t c, input col_t r);
    pix_t res;
    logic signed [ACC_W-1:0] ctr, orth, diag, acc;
    res = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      ctr  = samp(c[1], k);
      orth = samp(c[0], k) + samp(c[2], k) + samp(l[1], k) + samp(r[1], k);
      diag = samp(l[0], k) + samp(l[2], k) + samp(r[0], k) + samp(r[2], k);
      case (md)
        M_PASS:    acc = ctr;
        M_SHARPEN: acc = (ctr <<< 2) + ctr - orth;
        M_GAUSS:   acc = ((ctr <<< 2) + (orth <<< 1) + diag + ACC_W'(8)) >>> 4;
        default:   acc = (ctr <<< 3) - orth - diag;
      endcase
      if (acc[ACC_W-1])
        res[k*PIX_W +: PIX_W] = '0;
      else if (acc > PIX_MAX)
        res[k*PIX_W +: PIX_W] = '1;
      else
        res[k*PIX_W +: PIX_W] = acc[PIX_W-1:0];
    end
    return res;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; an accepted s_sof restarts the frame from any accepting state.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (restart) state_nx = S_FILL;
      S_FILL:  if (accept && !io.s_sof && (col == COL_LAST)) state_nx = S_RUN;
      S_RUN: begin
        if (restart)                            state_nx = S_FILL;
        else if (accept && (col == COL_LAST))   state_nx = S_EOL;
      end
      S_EOL:   if (out_free) state_nx = (row == ROW_LAST) ? S_FLUSH : S_RUN;
      S_FLUSH: if (out_free && (col == COL_LAST)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output-beat generation per state
  always_comb begin
    emit     = 1'b0;
    emit_sof = 1'b0;
    emit_eol = 1'b0;
    case (state)
      S_RUN: begin
        emit     = accept && !io.s_sof && (col != '0);
        emit_sof = (row == ROW_ONE) && (col == COL_ONE);
      end
      S_EOL: begin
        emit     = out_free;
        emit_eol = 1'b1;
      end
      S_FLUSH: begin
        emit     = out_free;
        emit_eol = (col == COL_LAST);
      end
      default: ;
    endcase
  end

  // Window taps. RUN: right column is {older row, previous row, incoming pixel}, with the
  // top zeroed while the window straddles row -1. EOL: right column is padding.
  // FLUSH: read both line buffers directly, bottom row is padding.
  always_comb begin
    tap_l = win_l_q;
    tap_c = win_c_q;
    tap_r = '0;
    case (state)
      S_RUN: begin
        tap_r[0] = (row == ROW_ONE) ? pix_t'(0) : line_b[col];
        tap_r[1] = line_a[col];
        tap_r[2] = io.s_data;
      end
      S_FLUSH: begin
        tap_l    = '0;
        tap_c    = '0;
        tap_c[0] = line_b[col];
        tap_c[1] = line_a[col];
        if (col != '0) begin
          tap_l[0] = line_b[col - COL_ONE];
          tap_l[1] = line_a[col - COL_ONE];
        end
        if (col != COL_LAST) begin
          tap_r[0] = line_b[col + COL_ONE];
          tap_r[1] = line_a[col + COL_ONE];
        end
      end
      default: ;
    endcase
  end

  assign result = kernel(mode_q, tap_l, tap_c, tap_r);

  // Counters, latched mode, output register and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      mode_q     <= M_PASS;
      io.m_valid <= 1'b0;
      io.m_sof   <= 1'b0;
      io.m_eol   <= 1'b0;
      io.m_data  <= '0;
      err_sof    <= 1'b0;
    end else begin
      err_sof <= (state == S_IDLE) && accept && !io.s_sof;

      if (emit) begin
        io.m_data  <= result;
        io.m_valid <= 1'b1;
        io.m_sof   <= emit_sof;
        io.m_eol   <= emit_eol;
      end else if (io.m_ready) begin
        io.m_valid <= 1'b0;
      end

      if (restart) begin
        row    <= '0;
        col    <= COL_ONE;
        mode_q <= mode_e'(mode);
      end else begin
        case (state)
          S_FILL: if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= ROW_ONE;
            end else begin
              col <= col + COL_ONE;
            end
          end
          // col parks on the last column through EOL
          S_RUN:   if (accept && (col != COL_LAST)) col <= col + COL_ONE;
          S_EOL: if (out_free) begin
            col <= '0;
            if (row != ROW_LAST) row <= row + ROW_ONE;
          end
          S_FLUSH: if (out_free) col <= (col == COL_LAST) ? '0 : col + COL_ONE;
          default: ;
        endcase
      end
    end
  end

  // Line buffers and window columns; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (io.s_sof) begin
        line_a[0] <= io.s_data;
      end else if (state == S_FILL) begin
        line_a[col] <= io.s_data;
      end else if (state == S_RUN) begin
        line_b[col] <= line_a[col];
        line_a[col] <= io.s_data;
        // x=0 starts a new line: the left padding column becomes the next left tap.
        win_l_q     <= (col == '0) ? col_t'(0) : win_c_q;
        win_c_q     <= tap_r;
      end
    end
  end

endmodule
